// File: rtl/note_lookup_sequencer.sv
// rtl/note_lookup_sequencer.sv - frequency to note-code lookup with stability filter
// Define NOTE_BINARY_SEARCH_EN for a fixed 5-cycle binary search instead of the linear scan.
module note_lookup_sequencer #(
    parameter int unsigned STABLE_COUNT = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        clear_in,
    input  logic [31:0] freq_in,
    input  logic        freq_valid_in,
    output logic        freq_ready_out,
    output logic [7:0]  note_code_out,
    output logic        note_active_out,
    output logic        note_valid_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_COUNT);

    // Lower bin edges; index 27 is the exclusive upper edge of the last bin.
    function automatic logic [10:0] bound(input logic [4:0] i);
        case (i)
            5'd0:    bound = 11'd220;
            5'd1:    bound = 11'd233;
            5'd2:    bound = 11'd247;
            5'd3:    bound = 11'd262;
            5'd4:    bound = 11'd277;
            5'd5:    bound = 11'd294;
            5'd6:    bound = 11'd311;
            5'd7:    bound = 11'd330;
            5'd8:    bound = 11'd349;
            5'd9:    bound = 11'd370;
            5'd10:   bound = 11'd392;
            5'd11:   bound = 11'd415;
            5'd12:   bound = 11'd440;
            5'd13:   bound = 11'd466;
            5'd14:   bound = 11'd494;
            5'd15:   bound = 11'd523;
            5'd16:   bound = 11'd554;
            5'd17:   bound = 11'd587;
            5'd18:   bound = 11'd622;
            5'd19:   bound = 11'd659;
            5'd20:   bound = 11'd698;
            5'd21:   bound = 11'd740;
            5'd22:   bound = 11'd784;
            5'd23:   bound = 11'd831;
            5'd24:   bound = 11'd880;
            5'd25:   bound = 11'd932;
            5'd26:   bound = 11'd988;
            default: bound = 11'd1047;
        endcase
    endfunction

    // Code 0 is never a real note (accidental field is 01 or 10), so it doubles as "none".
    function automatic logic [7:0] code_of(input logic [4:0] k);
        logic [4:0] m;
        logic [2:0] oct;
        logic [4:0] la;
        if (k >= 5'd24)      m = k - 5'd24;
        else if (k >= 5'd12) m = k - 5'd12;
        else                 m = k;
        if (k < 5'd3)        oct = 3'd3;
        else if (k < 5'd15)  oct = 3'd4;
        else                 oct = 3'd5;
        case (m)
            5'd0:    la = {3'd0, 2'b01};
            5'd1:    la = {3'd1, 2'b10};
            5'd2:    la = {3'd1, 2'b01};
            5'd3:    la = {3'd2, 2'b01};
            5'd4:    la = {3'd3, 2'b10};
            5'd5:    la = {3'd3, 2'b01};
            5'd6:    la = {3'd4, 2'b10};
            5'd7:    la = {3'd4, 2'b01};
            5'd8:    la = {3'd5, 2'b01};
            5'd9:    la = {3'd6, 2'b10};
            5'd10:   la = {3'd6, 2'b01};
            default: la = {3'd0, 2'b10};
        endcase
        code_of = {la, oct};
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] freq_q, freq_d;
    logic [7:0]  res_q, res_d;
    logic [7:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  code_q, code_d;
    logic        active_q, active_d;
    logic        valid_q, valid_d;
    logic        rst_ok_q, rst_ok_d;
    logic        oor;
`ifdef NOTE_BINARY_SEARCH_EN
    logic [4:0]  hi_q, hi_d;
    logic [2:0]  step_q, step_d;
    logic [4:0]  mid;
`endif

    assign freq_ready_out  = (state_q == IDLE) && !clear_in && rst_ok_q;
    assign busy_out        = (state_q != IDLE);
    assign note_code_out   = code_q;
    assign note_active_out = active_q;
    assign note_valid_out  = valid_q;
    assign oor             = (freq_q < 32'd220) || (freq_q >= 32'd1047);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        freq_d   = freq_q;
        res_d    = res_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        active_d = active_q;
        valid_d  = 1'b0;
        rst_ok_d = 1'b1;
`ifdef NOTE_BINARY_SEARCH_EN
        hi_d     = hi_q;
        step_d   = step_q;
        mid      = 5'((6'(idx_q) + 6'(hi_q) + 6'd1) >> 1);
`endif
        if (clear_in) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (freq_valid_in && freq_ready_out) begin
                        freq_d  = freq_in;
                        idx_d   = 5'd0;
                        state_d = SEARCH;
`ifdef NOTE_BINARY_SEARCH_EN
                        hi_d    = 5'd26;
                        step_d  = 3'd0;
`endif
                    end
                end
                SEARCH: begin
`ifdef NOTE_BINARY_SEARCH_EN
                    // idx holds the low end of the window; five halvings cover 27 bins.
                    if ({21'b0, bound(mid)} <= freq_q) idx_d = mid;
                    else                               hi_d  = mid - 5'd1;
                    step_d = step_q + 3'd1;
                    if (step_q == 3'd4) begin
                        state_d = DONE;
                        res_d   = oor ? 8'd0 : code_of(idx_d);
                    end
`else
                    if (idx_q == 5'd0 && oor) begin
                        res_d   = 8'd0;
                        state_d = DONE;
                    end else if (freq_q < {21'b0, bound(idx_q + 5'd1)}) begin
                        res_d   = code_of(idx_q);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
`endif
                end
                DONE: begin
                    if (res_q == cand_q) begin
                        cnt_d = (cnt_q >= STABLE) ? STABLE : cnt_q + 4'd1;
                    end else begin
                        cand_d = res_q;
                        cnt_d  = 4'd1;
                    end
                    if (cnt_d == STABLE && cand_d != code_q) begin
                        code_d   = cand_d;
                        active_d = (cand_d != 8'd0);
                        valid_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            idx_q    <= 5'd0;
            freq_q   <= 32'd0;
            res_q    <= 8'd0;
            cand_q   <= 8'd0;
            cnt_q    <= 4'd0;
            code_q   <= 8'd0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            rst_ok_q <= 1'b0;
`ifdef NOTE_BINARY_SEARCH_EN
            hi_q     <= 5'd0;
            step_q   <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            freq_q   <= freq_d;
            res_q    <= res_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            rst_ok_q <= rst_ok_d;
`ifdef NOTE_BINARY_SEARCH_EN
            hi_q     <= hi_d;
            step_q   <= step_d;
`endif
        end
    end

endmodule

// File: tb/tb_note_lookup_sequencer.sv
// tb/tb_note_lookup_sequencer.sv - directed self-checking bench for note_lookup_sequencer
module tb_note_lookup_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, clear, valid;
    logic [31:0] freq;
    logic        ready3, active3, vld3, busy3;
    logic        ready1, active1, vld1, busy1;
    logic [7:0]  code3, code1;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    note_lookup_sequencer #(.STABLE_COUNT(3)) dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .freq_in(freq),
        .freq_valid_in(valid), .freq_ready_out(ready3), .note_code_out(code3),
        .note_active_out(active3), .note_valid_out(vld3), .busy_out(busy3)
    );

    note_lookup_sequencer #(.STABLE_COUNT(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clear), .freq_in(freq),
        .freq_valid_in(valid), .freq_ready_out(ready1), .note_code_out(code1),
        .note_active_out(active1), .note_valid_out(vld1), .busy_out(busy1)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; valid = 1'b0; clear = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // cyc = busy samples after the accepting edge; e3 = dut3 pulse at the first idle sample.
    task automatic send(input logic [31:0] f, output int cyc, output int p3, output int p1, output int e3);
        int w;
        w = 0;
        while (!ready3 && w < 50) begin step(); w++; end
        total++;
        if (ready3 !== 1'b1) $display("FAIL send_ready f=%0d got=%b want=1", f, ready3);
        else passed++;
        freq = f; valid = 1'b1;
        step();
        valid = 1'b0;
        cyc = 0; p3 = 0; p1 = 0;
        while (busy3 && cyc < 100) begin
            cyc++; p3 += int'(vld3); p1 += int'(vld1);
            step();
        end
        p3 += int'(vld3); p1 += int'(vld1);
        e3 = int'(vld3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; valid = 1'b1; freq = 32'd440;
        step(); step();
        total++; if (code3 !== 8'h00) $display("FAIL reset_code got=%h want=00", code3); else passed++;
        total++; if (active3 !== 1'b0) $display("FAIL reset_active got=%b want=0", active3); else passed++;
        total++; if (vld3 !== 1'b0) $display("FAIL reset_valid got=%b want=0", vld3); else passed++;
        total++; if (busy3 !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy3); else passed++;
        total++; if (ready3 !== 1'b0) $display("FAIL reset_ready got=%b want=0", ready3); else passed++;
        rst_n = 1'b1;
        #2;
        total++; if (ready3 !== 1'b0) $display("FAIL release_ready got=%b want=0", ready3); else passed++;
        step();
        total++; if (busy3 !== 1'b0) $display("FAIL first_edge_busy got=%b want=0", busy3); else passed++;
        total++; if (ready3 !== 1'b1) $display("FAIL first_edge_ready got=%b want=1", ready3); else passed++;
        step();
        total++; if (busy3 !== 1'b1) $display("FAIL second_edge_accept got=%b want=1", busy3); else passed++;
        valid = 1'b0;
        apply_reset();
    endtask

    task automatic test_stable;
        int c, p3, p1, e3;
        send(32'd440, c, p3, p1, e3);
        send(32'd440, c, p3, p1, e3);
        total++; if (p3 != 0 || code3 !== 8'h00) $display("FAIL stable_early pulses=%0d code=%h want 0/00", p3, code3); else passed++;
        send(32'd440, c, p3, p1, e3);
        // pulse lands in cycle T+15: 14 busy samples, then the idle sample carries it
        total++; if (c != 14) $display("FAIL stable_latency got=%0d want=14", c); else passed++;
        total++; if (p3 != 1 || e3 != 1) $display("FAIL stable_pulse count=%0d at_end=%0d want 1/1", p3, e3); else passed++;
        total++; if (code3 !== 8'h0C || active3 !== 1'b1) $display("FAIL stable_code got=%h/%b want=0C/1", code3, active3); else passed++;
        step();
        total++; if (vld3 !== 1'b0) $display("FAIL stable_one_cycle got=%b want=0", vld3); else passed++;
    endtask

    task automatic test_change;
        int c, p3, p1, e3, early;
        early = 0;
        send(32'd262, c, p3, p1, e3); early += p3;
        send(32'd262, c, p3, p1, e3); early += p3;
        total++; if (early != 0 || code3 !== 8'h0C) $display("FAIL change_early pulses=%0d code=%h want 0/0C", early, code3); else passed++;
        send(32'd262, c, p3, p1, e3);
        total++; if (p3 != 1 || e3 != 1 || c != 5) $display("FAIL change_pulse pulses=%0d end=%0d cyc=%0d want 1/1/5", p3, e3, c); else passed++;
        total++; if (code3 !== 8'h4C || active3 !== 1'b1) $display("FAIL change_code got=%h/%b want=4C/1", code3, active3); else passed++;
        send(32'd262, c, p3, p1, e3);
        total++; if (p3 != 0 || code3 !== 8'h4C) $display("FAIL change_repeat pulses=%0d code=%h want 0/4C", p3, code3); else passed++;
    endtask

    task automatic test_edges;
        int c, p3, p1, e3;
        apply_reset();
        send(32'd219, c, p3, p1, e3);
        total++; if (p1 != 0 || code1 !== 8'h00 || active1 !== 1'b0) $display("FAIL edge_219 pulses=%0d code=%h act=%b want 0/00/0", p1, code1, active1); else passed++;
        send(32'd1046, c, p3, p1, e3);
        total++; if (p1 != 1 || code1 !== 8'h2D || active1 !== 1'b1) $display("FAIL edge_1046 pulses=%0d code=%h act=%b want 1/2D/1", p1, code1, active1); else passed++;
        send(32'd1047, c, p3, p1, e3);
        total++; if (p1 != 1 || code1 !== 8'h00 || active1 !== 1'b0) $display("FAIL edge_1047 pulses=%0d code=%h act=%b want 1/00/0", p1, code1, active1); else passed++;
    endtask

    task automatic test_alternate;
        int c, p3, p1, e3, sum;
        apply_reset();
        sum = 0;
        for (int i = 0; i < 10; i++) begin
            send((i % 2 == 0) ? 32'd440 : 32'd466, c, p3, p1, e3);
            sum += p3;
        end
        total++; if (sum != 0 || active3 !== 1'b0) $display("FAIL alternate pulses=%0d act=%b want 0/0", sum, active3); else passed++;
    endtask

    task automatic test_valid_held;
        int c, bad, w;
        w = 0;
        while (!ready3 && w < 50) begin step(); w++; end
        freq = 32'd440; valid = 1'b1;
        step();
        c = 0; bad = 0;
        while (busy3 && c < 100) begin
            c++;
            if (ready3) bad++;
            step();
        end
        valid = 1'b0;
        total++; if (bad != 0) $display("FAIL held_ready high_samples=%0d want=0", bad); else passed++;
        total++; if (c != 14) $display("FAIL held_no_reaccept busy=%0d want=14", c); else passed++;
    endtask

    task automatic test_reset_search;
        int c, p3, p1, e3, w;
        send(32'd494, c, p3, p1, e3);
        send(32'd494, c, p3, p1, e3);
        w = 0;
        while (!ready3 && w < 50) begin step(); w++; end
        freq = 32'd494; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (4) step();
        total++; if (busy3 !== 1'b1) $display("FAIL rsearch_busy got=%b want=1", busy3); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (busy3 !== 1'b0 || vld3 !== 1'b0 || ready3 !== 1'b0) $display("FAIL rsearch_state busy=%b vld=%b rdy=%b want 0/0/0", busy3, vld3, ready3); else passed++;
        total++; if (code3 !== 8'h00 || active3 !== 1'b0) $display("FAIL rsearch_outputs got=%h/%b want=00/0", code3, active3); else passed++;
        step(); step();
        rst_n = 1'b1;
        step();
        send(32'd494, c, p3, p1, e3);
        total++; if (p3 != 0 || c != 16) $display("FAIL rsearch_next pulses=%0d cyc=%0d want 0/16", p3, c); else passed++;
    endtask

    task automatic test_clear_done;
        int c, p3, p1, e3, w;
        apply_reset();
        repeat (3) send(32'd440, c, p3, p1, e3);
        send(32'd262, c, p3, p1, e3);
        send(32'd262, c, p3, p1, e3);
        w = 0;
        while (!ready3 && w < 50) begin step(); w++; end
        freq = 32'd262; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++; if (vld3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL clear_done vld=%b busy=%b want 0/0", vld3, busy3); else passed++;
        total++; if (code3 !== 8'h0C || active3 !== 1'b1) $display("FAIL clear_held got=%h/%b want=0C/1", code3, active3); else passed++;
        clear = 1'b1;
        #1;
        total++; if (ready3 !== 1'b0) $display("FAIL clear_ready got=%b want=0", ready3); else passed++;
        clear = 1'b0;
        #1;
        send(32'd262, c, p3, p1, e3);
        total++; if (p3 != 0 || c != 5) $display("FAIL clear_next pulses=%0d cyc=%0d want 0/5", p3, c); else passed++;
    endtask

    task automatic test_latency;
        int c, p3, p1, e3;
        int exp_lo, exp_hi, exp_oor;
`ifdef NOTE_BINARY_SEARCH_EN
        exp_lo = 6; exp_hi = 6; exp_oor = 6;
`else
        exp_lo = 2; exp_hi = 28; exp_oor = 2;
`endif
        apply_reset();
        send(32'd220, c, p3, p1, e3);
        total++; if (c != exp_lo || code1 !== 8'h0B) $display("FAIL lat_220 cyc=%0d code=%h want %0d/0B", c, code1, exp_lo); else passed++;
        send(32'd988, c, p3, p1, e3);
        total++; if (c != exp_hi || code1 !== 8'h2D) $display("FAIL lat_988 cyc=%0d code=%h want %0d/2D", c, code1, exp_hi); else passed++;
        send(32'd5000, c, p3, p1, e3);
        total++; if (c != exp_oor || code1 !== 8'h00 || active1 !== 1'b0) $display("FAIL lat_5000 cyc=%0d code=%h act=%b want %0d/00/0", c, code1, active1, exp_oor); else passed++;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; valid = 1'b0; freq = 32'd0;
        test_reset();
        test_stable();
        test_change();
        test_edges();
        test_alternate();
        test_valid_held();
        test_reset_search();
        test_clear_done();
        test_latency();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
